// File: rtl/sopc_base_btn_pkg.sv
// Shared types and constants for the push-button controller: debounce states,
// Avalon register addresses and edge-capture mode selection.
package sopc_base_btn_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } deb_state_e;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE    = 2'd2;
  localparam logic [1:0] ADDR_RAW     = 2'd3;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_BOTH = 2;

  function automatic logic edge_match(input int mode, input logic prev_lvl, input logic new_lvl);
    logic fall;
    logic rise;
    fall = prev_lvl & ~new_lvl;
    rise = ~prev_lvl & new_lvl;
    case (mode)
      EDGE_RISE: return rise;
      EDGE_BOTH: return fall | rise;
      default:   return fall;
    endcase
  endfunction

endpackage

// File: rtl/sopc_base_btn_debounce.sv
// One button: 2-FF synchroniser, STABLE/COUNT debounce FSM and a single-cycle
// edge pulse issued on the same cycle the debounced level changes.
module sopc_base_btn_debounce
  import sopc_base_btn_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   CNT_W           = 19,
  parameter int   EDGE_MODE       = EDGE_FALL,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_deb,
  output logic o_edge
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  deb_state_e       r_state;
  deb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_deb;
  logic             w_deb_nxt;
  logic             w_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= IDLE_LEVEL;
      r_sync <= IDLE_LEVEL;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_deb   <= IDLE_LEVEL;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_deb   <= w_deb_nxt;
    end
  end

  // The terminal compare exits COUNT before the counter could ever wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_deb_nxt   = r_deb;
    w_edge      = 1'b0;
    case (r_state)
      STABLE: begin
        w_cnt_nxt = '0;
        if (r_sync != r_deb) w_state_nxt = COUNT;
      end
      COUNT: begin
        if (r_sync == r_deb) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_deb_nxt   = r_sync;
          w_edge      = edge_match(EDGE_MODE, r_deb, r_sync);
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_sync = r_sync;
  assign o_deb  = r_deb;
  assign o_edge = w_edge;

endmodule

// File: rtl/sopc_base_button_ctrl.sv
// Avalon-MM push-button controller: debounced levels, sticky W1C edge capture,
// registered read data. Define SOPC_BTN_IRQ_EN to build the irqmask register and irq.
module sopc_base_button_ctrl
  import sopc_base_btn_pkg::*;
#(
  parameter int   NB_BTN          = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   CNT_W           = 19,
  parameter int   EDGE_MODE       = EDGE_FALL,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [NB_BTN-1:0] in_port,
  output logic              irq
);

  logic [NB_BTN-1:0] w_sync;
  logic [NB_BTN-1:0] w_deb;
  logic [NB_BTN-1:0] w_edge;
  logic [NB_BTN-1:0] w_irqmask;
  logic [NB_BTN-1:0] w_clr;
  logic [NB_BTN-1:0] r_edgecap;
  logic [31:0]       w_rd_mux;
  logic [31:0]       r_readdata;
  logic              w_wr;
  logic              w_unused_wdata;

  for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
    sopc_base_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .EDGE_MODE       (EDGE_MODE),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .i_pin  (in_port[g]),
      .o_sync (w_sync[g]),
      .o_deb  (w_deb[g]),
      .o_edge (w_edge[g])
    );
  end

  assign w_wr           = chipselect & write;
  assign w_clr          = (w_wr && address == ADDR_EDGE) ? writedata[NB_BTN-1:0] : '0;
  assign w_unused_wdata = ^writedata[31:NB_BTN];

  // A new edge overrides a same-cycle clear of that bit.
  always_ff @(posedge clk) begin
    if (reset) r_edgecap <= '0;
    else       r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
  end

`ifdef SOPC_BTN_IRQ_EN
  logic [NB_BTN-1:0] r_irqmask;
  logic              r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irqmask <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && address == ADDR_IRQMASK) r_irqmask <= writedata[NB_BTN-1:0];
      r_irq <= |(r_edgecap & r_irqmask);
    end
  end

  assign w_irqmask = r_irqmask;
  assign irq       = r_irq;
`else
  assign w_irqmask = '0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:    w_rd_mux[NB_BTN-1:0] = w_deb;
      ADDR_IRQMASK: w_rd_mux[NB_BTN-1:0] = w_irqmask;
      ADDR_EDGE:    w_rd_mux[NB_BTN-1:0] = r_edgecap;
      ADDR_RAW:     w_rd_mux[NB_BTN-1:0] = w_sync;
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)           r_readdata <= '0;
    else if (chipselect) r_readdata <= w_rd_mux;
    else                 r_readdata <= '0;
  end

  assign readdata = r_readdata;

endmodule

// File: tb/tb_sopc_base_button_ctrl.sv
// Bench for sopc_base_button_ctrl: directed vector table, reset-mid-count sequence,
// then randomized traffic against a run-length reference model.
module tb_sopc_base_button_ctrl;

  localparam int NB  = 2;
  localparam int DEB = 4;
`ifdef SOPC_BTN_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [NB-1:0] in_port;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sopc_base_button_ctrl #(
    .NB_BTN          (NB),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (3),
    .EDGE_MODE       (0),
    .IDLE_LEVEL      (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  // Reference model: the debounced level flips once the synchronised input has
  // disagreed with it for DEB+1 consecutive clocks; pins reach sync two clocks late.
  logic [NB-1:0] m_meta, m_sync, m_deb, m_edgecap, m_mask, m_edg;
  logic [31:0]   m_rd, m_rd_nxt;
  logic          m_irq;
  int            m_run [NB];

  always @(posedge clk) begin
    m_rd_nxt = '0;
    if (chipselect) begin
      case (address)
        2'd0: m_rd_nxt[NB-1:0] = m_deb;
        2'd1: m_rd_nxt[NB-1:0] = IRQ_EN ? m_mask : '0;
        2'd2: m_rd_nxt[NB-1:0] = m_edgecap;
        default: m_rd_nxt[NB-1:0] = m_sync;
      endcase
    end
    if (reset) begin
      m_rd = '0; m_irq = 1'b0; m_mask = '0; m_edgecap = '0;
      m_deb = '1; m_meta = '1; m_sync = '1;
      for (int b = 0; b < NB; b++) m_run[b] = 0;
    end else begin
      m_rd  = m_rd_nxt;
      m_irq = IRQ_EN && (|(m_edgecap & m_mask));
      m_edg = '0;
      for (int b = 0; b < NB; b++) begin
        if (m_sync[b] != m_deb[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB + 1) begin
            m_edg[b] = m_deb[b] && !m_sync[b];
            m_deb[b] = m_sync[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      if (chipselect && write && address == 2'd2) m_edgecap = m_edgecap & ~writedata[NB-1:0];
      m_edgecap = m_edgecap | m_edg;
      if (chipselect && write && address == 2'd1) m_mask = writedata[NB-1:0];
      m_sync = m_meta;
      m_meta = in_port;
    end
  end

  typedef struct {
    logic [NB-1:0] pin;
    logic          cs;
    logic          wr;
    logic [1:0]    addr;
    logic [31:0]   wd;
    int            cyc;
    logic [31:0]   exp_rd;
    logic          exp_irq;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [NB-1:0] pin, logic cs, logic wr, logic [1:0] a,
                              logic [31:0] wd, int cyc, logic [31:0] rd, logic iq);
    vec_t v;
    v.pin = pin; v.cs = cs; v.wr = wr; v.addr = a; v.wd = wd;
    v.cyc = cyc; v.exp_rd = rd; v.exp_irq = iq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [NB-1:0] pin, input logic cs, input logic wr,
                       input logic [1:0] a, input logic [31:0] wd);
    in_port = pin; chipselect = cs; write = wr; address = a; writedata = wd;
  endtask

  logic [31:0] I1, I3;
  int          hold [NB];

  initial begin
    I1 = IRQ_EN ? 32'd1 : 32'd0;
    I3 = IRQ_EN ? 32'd3 : 32'd0;
    vt.push_back(mk(2'b11, 1, 0, 2'd0, 0, 1, 32'h3, 0));
    vt.push_back(mk(2'b11, 1, 0, 2'd2, 0, 1, 32'h0, 0));
    vt.push_back(mk(2'b11, 1, 0, 2'd3, 0, 1, 32'h3, 0));
    vt.push_back(mk(2'b10, 1, 0, 2'd0, 0, 7, 32'h3, 0));
    vt.push_back(mk(2'b10, 1, 0, 2'd0, 0, 1, 32'h2, 0));
    vt.push_back(mk(2'b10, 1, 0, 2'd2, 0, 1, 32'h1, 0));
    vt.push_back(mk(2'b10, 1, 0, 2'd3, 0, 1, 32'h2, 0));
    vt.push_back(mk(2'b00, 1, 0, 2'd0, 0, 2, 32'h2, 0));
    vt.push_back(mk(2'b10, 1, 0, 2'd0, 0, 8, 32'h2, 0));
    vt.push_back(mk(2'b10, 1, 0, 2'd2, 0, 1, 32'h1, 0));
    vt.push_back(mk(2'b10, 1, 1, 2'd2, 32'hFFFF_FFFF, 1, 32'h1, 0));
    vt.push_back(mk(2'b10, 1, 0, 2'd2, 0, 1, 32'h0, 0));
    vt.push_back(mk(2'b10, 1, 1, 2'd1, 32'h1, 1, 32'h0, 0));
    vt.push_back(mk(2'b10, 1, 0, 2'd1, 0, 1, I1, 0));
    vt.push_back(mk(2'b11, 1, 0, 2'd0, 0, 8, 32'h3, 0));
    vt.push_back(mk(2'b11, 1, 0, 2'd2, 0, 1, 32'h0, 0));
    vt.push_back(mk(2'b10, 1, 0, 2'd2, 0, 7, 32'h0, 0));
    vt.push_back(mk(2'b10, 1, 0, 2'd2, 0, 1, 32'h1, IRQ_EN));
    vt.push_back(mk(2'b10, 1, 1, 2'd2, 32'h1, 1, 32'h1, IRQ_EN));
    vt.push_back(mk(2'b10, 1, 0, 2'd2, 0, 1, 32'h0, 0));
    vt.push_back(mk(2'b00, 1, 0, 2'd0, 0, 6, 32'h2, 0));
    vt.push_back(mk(2'b00, 1, 1, 2'd2, 32'h2, 1, 32'h0, 0));
    vt.push_back(mk(2'b00, 1, 0, 2'd2, 0, 1, 32'h2, 0));
    vt.push_back(mk(2'b00, 1, 0, 2'd0, 0, 1, 32'h0, 0));
    vt.push_back(mk(2'b00, 0, 0, 2'd2, 0, 1, 32'h0, 0));
    vt.push_back(mk(2'b00, 1, 1, 2'd1, 32'h3, 1, I1, 0));
    vt.push_back(mk(2'b00, 1, 0, 2'd1, 0, 1, I3, IRQ_EN));
    vt.push_back(mk(2'b00, 1, 1, 2'd2, 32'h2, 1, 32'h2, IRQ_EN));
    vt.push_back(mk(2'b00, 1, 0, 2'd2, 0, 1, 32'h0, 0));

    reset = 1'b1;
    drive(2'b11, 1, 0, 2'd0, 0);
    repeat (3) @(negedge clk);
    chk("reset readdata", readdata, 32'h0);
    chk("reset irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].pin, vt[i].cs, vt[i].wr, vt[i].addr, vt[i].wd);
      repeat (vt[i].cyc) @(negedge clk);
      chk($sformatf("vec%0d readdata", i), readdata, vt[i].exp_rd);
      chk($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vt[i].exp_irq});
    end

    // Reset two cycles into a press of button 0; no edge may appear afterwards.
    drive(2'b11, 1, 0, 2'd0, 0);
    repeat (10) @(negedge clk);
    chk("pre-reset deb", readdata, 32'h3);
    drive(2'b10, 1, 0, 2'd0, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    drive(2'b11, 1, 0, 2'd0, 0);
    repeat (2) @(negedge clk);
    chk("midcount reset readdata", readdata, 32'h0);
    chk("midcount reset irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    drive(2'b11, 1, 0, 2'd2, 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset edgecap c%0d", c), readdata, 32'h0);
    end
    drive(2'b11, 1, 0, 2'd0, 0);
    @(negedge clk);
    chk("post-reset deb", readdata, 32'h3);
    drive(2'b11, 1, 0, 2'd1, 0);
    @(negedge clk);
    chk("post-reset irqmask", readdata, 32'h0);
    chk("post-reset irq", {31'b0, irq}, 32'h0);

    // Randomized traffic checked every cycle against the model.
    for (int b = 0; b < NB; b++) hold[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (hold[b] == 0) begin
          in_port[b] = 1'($urandom_range(0, 1));
          hold[b]    = $urandom_range(1, 10);
        end
        hold[b]--;
      end
      reset      = ($urandom_range(0, 499) == 0);
      chipselect = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom_range(0, 3));
      write      = ($urandom_range(0, 5) == 0);
      writedata  = $urandom;
      @(negedge clk);
      chk($sformatf("rand c%0d readdata", c), readdata, m_rd);
      chk($sformatf("rand c%0d irq", c), {31'b0, irq}, {31'b0, m_irq});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
